rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-input, WIDTH-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output, plus a one-entry registered output stage. Replaces fixed-select combinational muxes wherever several producers share one consumer, e.g. multiple CPU-side requesters funnelling into one memory/bus port. Selection is round-robin rather than an external `sel`. Multi-beat bursts marked with `last` are kept contiguous by locking the grant.

## Interface
- `N_IN`, default 4: number of input channels, ≥1.
- `WIDTH`, default 32: data width in bits, ≥1.
- `SRC_W`, derived as (N_IN>1) ? $clog2(N_IN) : 1: width of the source index. It is a localparam and not overridable.

- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input N_IN*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input N_IN: per-channel valid.
- `in_last` input N_IN: per-channel end-of-burst flag, sampled with data.
- `in_ready` output N_IN: per-channel ready. At most one bit is high in any cycle.
- `out_data` output WIDTH: registered data.
- `out_last` output 1: registered last flag.
- `out_src` output SRC_W: registered index of the channel that supplied the current output beat.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts the beat.

## Operation
- **Handshake rules.** An input beat transfers when in_valid[i] & in_ready[i]. An output beat transfers when out_valid & out_ready.
- **Accept condition.** can_accept = !out_valid | out_ready. This gives a full-throughput pipe: one beat per cycle when the consumer is always ready.
- **Arbitration state.** Rotating pointer `ptr` (SRC_W bits) plus lock state `{UNLOCKED, LOCKED}` with a locked channel `lch`.
- **UNLOCKED.** `grant` is the first i with in_valid[i]=1, searching ptr, ptr+1, … with wrap modulo N_IN. If no input is valid, there is no grant and in_ready = 0.
- **LOCKED.** `grant` = lch, regardless of other valids.
- **Ready.** in_ready[i] = (i == grant) & can_accept & (UNLOCKED ? in_valid[i] : 1). Ready is combinational from in_valid and out_ready; there is no combinational path to in_data.
- **On an input transfer from channel g:**
  - Load out_data, out_last and out_src ← g; set out_valid = 1.
  - If in_last[g] = 0: enter or stay LOCKED with lch = g; ptr is unchanged.
  - If in_last[g] = 1: go UNLOCKED and set ptr ← (g+1) mod N_IN. For non-power-of-2 N_IN, wrap explicitly from N_IN−1 to 0.
- **Output drain.** If the output transfers with no new input transfer in the same cycle, clear out_valid. out_data, out_last and out_src hold their last values.
- **Locked channel goes quiet.** If the locked channel deasserts in_valid mid-burst, the lock holds. Other channels stay stalled until lch delivers its last beat.
- **Single-beat traffic.** Every beat has in_last = 1, so the block degenerates to a per-beat round-robin mux.
- **N_IN = 1.** Always grants channel 0; ptr and out_src stay 0.

## Timing
- **Reset values** (rst high at a clk edge): out_valid=0, out_data=0, out_last=0, out_src=0, ptr=0, state=UNLOCKED, lch=0.
- **Reset priority.** Reset overrides any simultaneous transfer. A burst in flight is dropped and the lock is cleared.
- **in_ready during reset.** in_ready is forced to 0 while rst=1.
- **Latency.** 1 cycle. A beat accepted at edge k appears on out_* after edge k and is valid in cycle k+1.
- **Back-to-back transfers.** Input and output transfers in the same cycle are permitted and required for full throughput. Data is never duplicated or lost.
- **Backpressure.** While out_valid=1 and out_ready=0, all in_ready are 0 and out_* are stable.
- **Pointer/lock update timing.** ptr and lock update at the same edge as the input transfer. Arbitration in the following cycle uses the new values.

## Test plan
- **Reset.** Drive rst=1 with all in_valid=1 → all in_ready=0. After release, out_valid=0 and out_src=0. With out_ready=1, channel 0 is granted first.
- **Round-robin fairness.** N_IN=4, all channels valid with last=1, data = 0xA0+i, out_ready=1 → out_src sequence 0,1,2,3,0,… with out_data 0xA0,0xA1,0xA2,0xA3. Throughput is 1 beat/cycle.
- **Burst lock.** Channel 2 sends 3 beats (last=0,0,1) while channel 3 is valid → outputs src 2,2,2, then src 3. ptr=3 after the burst.
- **Backpressure.** Hold out_ready=0 for 5 cycles with the output full → out_data stable and in_ready=0. Release → each pending beat is delivered exactly once.
- **Non-power-of-2 wrap.** N_IN=3 with channels 0 and 2 valid, after a grant to 2 → next grant is 0 and ptr wraps 2→0. Index 3 never appears.
- **Reset mid-burst.** Channel 1 has delivered last=0 and is locked; assert rst → lock cleared. After reset, channel 0 (if valid) is granted first.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N_IN producer channels in, one registered beat out.
// The master view is the producers-plus-consumer side; the slave view is the arbiter itself.
interface rr_arb_mux_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32
);
  localparam int SRC_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_last;
  logic [N_IN-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SRC_W-1:0]      out_src;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_src, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating mux with burst locking and a one-entry registered output stage.
// Grant is locked to a channel from its first non-last beat until its last beat is accepted.
module rr_arb_mux #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  rr_arb_mux_if.slave bus
);
  localparam int SRC_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] lch_q, lch_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  logic [SRC_W-1:0] grant;
  logic             grant_vld;
  logic             can_accept;
  logic             xfer;
  logic [N_IN-1:0]  ready;

  // Explicit wrap so non-power-of-2 channel counts never produce an out-of-range index.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    if (int'(i) >= N_IN - 1) return '0;
    else return i + 1'b1;
  endfunction

  assign can_accept = !valid_q || bus.out_ready;

  always_comb begin
    logic [SRC_W-1:0] idx;
    int               c;
    grant     = lch_q;
    grant_vld = 1'b0;
    idx       = '0;
    c         = 0;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        c = int'(ptr_q) + k;
        if (c >= N_IN) c = c - N_IN;
        idx = SRC_W'(c);
        if (!grant_vld && bus.in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // A locked channel is offered ready even while it idles, so the burst resumes without a bubble.
  always_comb begin
    ready = '0;
    if (!rst && grant_vld && can_accept &&
        (state_q == LOCKED || bus.in_valid[grant]))
      ready[grant] = 1'b1;
  end

  assign xfer         = |(ready & bus.in_valid);
  assign bus.in_ready = ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lch_d   = lch_q;
    src_d   = src_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = bus.in_data[grant*WIDTH +: WIDTH];
      last_d  = bus.in_last[grant];
      src_d   = grant;
      valid_d = 1'b1;
      if (bus.in_last[grant]) begin
        state_d = UNLOCKED;
        ptr_d   = wrap_inc(grant);
      end else begin
        state_d = LOCKED;
        lch_d   = grant;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ptr_q   <= '0;
      lch_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lch_q   <= lch_d;
      src_q   <= src_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 4-channel and a 3-channel instance run side by side against
// a per-cycle behavioural model of the arbitration rules.
module tb_rr_arb_mux;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.N_IN(4), .WIDTH(W)) b4 ();
  rr_arb_mux_if #(.N_IN(3), .WIDTH(W)) b3 ();

  rr_arb_mux #(.N_IN(4), .WIDTH(W)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  rr_arb_mux #(.N_IN(3), .WIDTH(W)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // Stimulus and model state, index 0 = 4-channel instance, index 1 = 3-channel instance.
  logic [3:0]   s_valid [2];
  logic [3:0]   s_last  [2];
  logic [W-1:0] s_data  [2][4];
  logic         s_ordy  [2];

  bit           m_ov   [2];
  logic [W-1:0] m_od   [2];
  bit           m_ol   [2];
  int           m_os   [2];
  int           m_ptr  [2];
  bit           m_lock [2];
  int           m_lch  [2];
  int           m_g    [2];
  int           m_xsrc [2];
  logic [3:0]   m_rdy  [2];

  int n_chk  = 0;
  int n_pass = 0;
  int bcnt [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int nch(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  task automatic apply();
    b4.in_valid  = s_valid[0];
    b4.in_last   = s_last[0];
    b4.out_ready = s_ordy[0];
    for (int i = 0; i < 4; i++) b4.in_data[i*W +: W] = s_data[0][i];
    b3.in_valid  = s_valid[1][2:0];
    b3.in_last   = s_last[1][2:0];
    b3.out_ready = s_ordy[1];
    for (int i = 0; i < 3; i++) b3.in_data[i*W +: W] = s_data[1][i];
  endtask

  function automatic void model_ready(input int u);
    int n;
    n = nch(u);
    m_rdy[u] = '0;
    m_g[u]   = -1;
    if (m_lock[u]) m_g[u] = m_lch[u];
    else
      for (int k = 0; k < n; k++)
        if (m_g[u] < 0 && s_valid[u][(m_ptr[u] + k) % n]) m_g[u] = (m_ptr[u] + k) % n;
    if (!rst && m_g[u] >= 0 && (!m_ov[u] || s_ordy[u])) m_rdy[u][m_g[u]] = 1'b1;
  endfunction

  function automatic void model_clock(input int u);
    int g;
    g = m_g[u];
    m_xsrc[u] = -1;
    if (rst) begin
      m_ov[u] = 0; m_od[u] = '0; m_ol[u] = 0; m_os[u] = 0;
      m_ptr[u] = 0; m_lock[u] = 0; m_lch[u] = 0;
    end else if (g >= 0 && m_rdy[u][g] && s_valid[u][g]) begin
      m_xsrc[u] = g;
      m_ov[u] = 1; m_od[u] = s_data[u][g]; m_ol[u] = s_last[u][g]; m_os[u] = g;
      if (s_last[u][g]) begin
        m_lock[u] = 0;
        m_ptr[u]  = (g + 1) % nch(u);
      end else begin
        m_lock[u] = 1;
        m_lch[u]  = g;
      end
    end else if (m_ov[u] && s_ordy[u]) begin
      m_ov[u] = 0;
    end
  endfunction

  task automatic cycle();
    apply();
    #1;
    model_ready(0);
    model_ready(1);
    chk("in_ready4", 64'(b4.in_ready), 64'(m_rdy[0]));
    chk("in_ready3", 64'(b3.in_ready), 64'(m_rdy[1][2:0]));
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
    chk("out_valid4", 64'(b4.out_valid), 64'(m_ov[0]));
    chk("out_data4",  64'(b4.out_data),  64'(m_od[0]));
    chk("out_last4",  64'(b4.out_last),  64'(m_ol[0]));
    chk("out_src4",   64'(b4.out_src),   64'(m_os[0]));
    chk("out_valid3", 64'(b3.out_valid), 64'(m_ov[1]));
    chk("out_data3",  64'(b3.out_data),  64'(m_od[1]));
    chk("out_last3",  64'(b3.out_last),  64'(m_ol[1]));
    chk("out_src3",   64'(b3.out_src),   64'(m_os[1]));
  endtask

  task automatic set_all(input logic [3:0] v, input logic [3:0] l, input logic r);
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = v;
      s_last[u]  = l;
      s_ordy[u]  = r;
      for (int i = 0; i < 4; i++) s_data[u][i] = W'(16'h00A0 + i);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ov[u] = 0; m_od[u] = '0; m_ol[u] = 0; m_os[u] = 0;
      m_ptr[u] = 0; m_lock[u] = 0; m_lch[u] = 0; m_g[u] = -1; m_xsrc[u] = -1;
      m_rdy[u] = '0; bcnt[u] = 0;
    end
    rst = 1'b1;
    set_all(4'hF, 4'hF, 1'b1);

    // Reset with every channel requesting, then plain round-robin of single beats.
    do_reset(3);
    for (int c = 0; c < 9; c++) cycle();

    // Channel 2 sends a 3-beat burst while channel 3 competes.
    do_reset(1);
    set_all(4'b1100, 4'b1000, 1'b1);
    for (int c = 0; c < 8; c++) begin
      for (int u = 0; u < 2; u++) s_last[u][2] = (bcnt[u] >= 2);
      cycle();
      for (int u = 0; u < 2; u++) if (m_xsrc[u] == 2) bcnt[u]++;
    end

    // Output backpressure, then release.
    set_all(4'hF, 4'hF, 1'b0);
    for (int c = 0; c < 6; c++) cycle();
    set_all(4'hF, 4'hF, 1'b1);
    for (int c = 0; c < 6; c++) cycle();

    // Only channels 0 and 2: exercises the wrap on the 3-channel instance.
    do_reset(1);
    set_all(4'b0101, 4'hF, 1'b1);
    for (int c = 0; c < 8; c++) cycle();

    // Lock channel 1 mid-burst, then reset while it and channel 0 request.
    do_reset(1);
    set_all(4'b0010, 4'b0000, 1'b1);
    for (int c = 0; c < 2; c++) cycle();
    set_all(4'b0011, 4'b0000, 1'b1);
    do_reset(1);
    set_all(4'b0011, 4'b0011, 1'b1);
    for (int c = 0; c < 4; c++) cycle();

    // Randomised traffic with varying request, burst and backpressure densities.
    for (int c = 0; c < 3000; c++) begin
      int vp;
      int rp;
      vp = (c / 500) % 3 == 0 ? 30 : ((c / 500) % 3 == 1 ? 70 : 95);
      rp = (c / 300) % 2 == 0 ? 90 : 40;
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < 4; i++) begin
          s_valid[u][i] = ($urandom_range(99) < vp);
          s_last[u][i]  = ($urandom_range(2) == 0);
          s_data[u][i]  = W'($urandom);
        end
        s_ordy[u] = ($urandom_range(99) < rp);
      end
      rst = ($urandom_range(299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
